vscale_dmem_bridge: RTL and testbench
=====================================

// Module: vscale_dmem_bridge
// PURPOSE
//  Data-memory port adapter directly downstream of the vscale pipeline's dmem interface.
//  Takes the two-phase pipeline access (address in DX, store data one cycle later in WB) and turns it into one
//  valid/ready bus request, then one response. Drives dmem_wait until the response returns.
//  Returns load data and bus/alignment errors on dmem_rdata and dmem_badmem_e.
// PARAMETERS
//  ADDR_W      32   address width (= `XPR_LEN)
//  DATA_W      32   data width (= `XPR_LEN); strobe width DATA_W/8
//  TIMEOUT     255  max cycles in RESP before forced error; 0 = no timeout; counter 8 bits
// PORTS
//  clk                 in   1       clock
//  reset_n             in   1       asynchronous, active-low reset
//  dmem_en             in   1       pipeline access request (DX stage)
//  dmem_wen            in   1       1=store, 0=load
//  dmem_size           in   3       0=byte, 1=half, 2=word; other values are treated as word
//  dmem_addr           in   ADDR_W  byte address (DX stage)
//  dmem_wdata_delayed  in   DATA_W  store data, valid the cycle after dmem_en is accepted (lanes pre-replicated)
//  dmem_wait           out  1       stall the pipeline
//  dmem_rdata          out  DATA_W  load data, valid in the cycle dmem_wait falls
//  dmem_badmem_e       out  1       access error, valid in the same cycle as dmem_rdata
//  bus_req_valid       out  1       bus request valid
//  bus_req_ready       in   1       bus accepts the request
//  bus_req_wen         out  1       write
//  bus_req_addr        out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  bus_req_wdata       out  DATA_W  store data
//  bus_req_strb        out  DATA_W/8 byte enables
//  bus_resp_valid      in   1       response valid
//  bus_resp_rdata      in   DATA_W  response data
//  bus_resp_err        in   1       response error
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; every output, the latched request and the counter clear to 0.
//    A bus transaction in flight is abandoned; the bus is reset together with this block.
//  States: IDLE, ISSUE, RESP, DONE.
//  IDLE/DONE + dmem_en=1:
//    latch addr, wen, size; compute strb; dmem_wait=0 in this cycle.
//    Aligned -> ISSUE. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE, err=1.
//  IDLE/DONE + dmem_en=0 -> IDLE; dmem_badmem_e=0.
//  ISSUE:
//    bus_req_valid=1 and dmem_wait=1.
//    bus_req_wdata = dmem_wdata_delayed, sampled into a holding reg on the first ISSUE cycle and stable while valid.
//    Request fields are stable until accepted. valid&ready -> RESP; count=0.
//  RESP:
//    dmem_wait=1.
//    bus_resp_valid -> capture rdata and err into regs -> DONE.
//    Timeout: count increments each cycle; count==TIMEOUT (TIMEOUT!=0) -> DONE, err=1, rdata=0.
//  DONE:
//    dmem_wait=0; dmem_rdata/dmem_badmem_e driven from regs for exactly this cycle, else rdata held, badmem=0.
//    A new dmem_en in DONE is accepted, giving back-to-back accesses.
//  dmem_en while in ISSUE/RESP is ignored; the pipeline holds it stalled and it is re-sampled in DONE.
//  bus_resp_valid outside RESP is ignored (protocol violation; bench flags it).
//  bus_req_ready and bus_resp_valid can both be asserted in the cycle ISSUE ends.
//    The response is taken only in RESP, minimum one cycle later.
//  Strobes: byte=4'b0001<<addr[1:0]; half=4'b0011<<{addr[1],1'b0}; word=4'hf.
//    Load strobes are the same; the pipeline does the load extraction.
//  Minimum stall with ready and resp both immediate:
//    WB stage sees dmem_wait=1 for 2 cycles (ISSUE, RESP); data arrives in the 3rd (DONE).
// CONFIGURATION
//  VSCALE_DMEM_BRIDGE_FASTRESP_EN defined:
//    in RESP with bus_resp_valid=1, dmem_wait=0 in that same cycle.
//    dmem_rdata=bus_resp_rdata and dmem_badmem_e=bus_resp_err are driven combinationally.
//    Next state is IDLE, or ISSUE/DONE if dmem_en is accepted in that cycle; the minimum stall drops to 1 cycle.
//  Undefined: fully registered response via DONE, as above; no combinational path from bus_resp_* to dmem_*.
// TESTING
//  Aligned word load 0x100, ready=1, resp next cycle with 0xDEADBEEF:
//    wait=1 for 2 cycles, then rdata=0xDEADBEEF, badmem=0.
//  Byte store addr=0x103, wdata=0x5A5A5A5A (sent the cycle after en):
//    req wen=1, addr=0x100, strb=4'b1000, wdata=0x5A5A5A5A, held stable while ready=0 for 3 cycles.
//  Half load addr=0x201:
//    no bus_req_valid; DONE cycle shows badmem=1, wait=0.
//  Load with resp_err=1:
//    badmem=1 in DONE. With TIMEOUT=4 and no resp: badmem=1 after 4 RESP cycles.
//  Two back-to-back loads (dmem_en held in DONE):
//    second request issues with no IDLE gap; both rdata values return in order.
//  reset_n low during RESP:
//    all outputs 0 at once, state IDLE; a later resp_valid is ignored.
//    Repeat the whole suite with FASTRESP_EN: stall is 1 cycle shorter and rdata appears in the resp cycle.

Source files
------------

// File: rtl/vscale_dmem_bridge.sv
// vscale dmem bridge: turns the two-phase pipeline dmem access into one valid/ready bus request and response.
// Latency: min 2 stall cycles (ISSUE, RESP), data in DONE; 1 stall cycle with VSCALE_DMEM_BRIDGE_FASTRESP_EN.
// Backpressure: request fields held until bus_req_ready; dmem_wait stalls the pipeline until the response is back.
module vscale_dmem_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  dmem_en,
   input  logic                  dmem_wen,
   input  logic [2:0]            dmem_size,
   input  logic [ADDR_W-1:0]     dmem_addr,
   input  logic [DATA_W-1:0]     dmem_wdata_delayed,
   output logic                  dmem_wait,
   output logic [DATA_W-1:0]     dmem_rdata,
   output logic                  dmem_badmem_e,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic                  bus_req_wen,
   output logic [ADDR_W-1:0]     bus_req_addr,
   output logic [DATA_W-1:0]     bus_req_wdata,
   output logic [DATA_W/8-1:0]   bus_req_strb,
   input  logic                  bus_resp_valid,
   input  logic [DATA_W-1:0]     bus_resp_rdata,
   input  logic                  bus_resp_err
);

   localparam int         STRB_W      = DATA_W / 8;
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

   state_t              state;
   logic [7:0]          count;
   logic [7:0]          count_nxt;
   logic                wait_q;
   logic                badmem_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                first_issue;   // set only during the first ISSUE cycle, when store data is on the input
   logic                fast_hit;      // response returned straight to the pipeline this cycle
   logic                accept;        // a new pipeline access is taken this cycle
   logic                misal;
   logic [STRB_W-1:0]   strb_new;

`ifdef VSCALE_DMEM_BRIDGE_FASTRESP_EN
   assign fast_hit = (state == RESP) && bus_resp_valid;
`else
   assign fast_hit = 1'b0;
`endif

   assign accept    = dmem_en && ((state == IDLE) || (state == DONE) || fast_hit);
   assign count_nxt = count + 8'd1;

   // The pipeline stall drops in the response cycle itself when the fast path is hit
   assign dmem_wait     = wait_q && !fast_hit;
   assign dmem_rdata    = fast_hit ? bus_resp_rdata : rdata_q;
   assign dmem_badmem_e = fast_hit ? bus_resp_err   : badmem_q;
   // Store data is only valid on the input in the first ISSUE cycle; afterwards the captured copy is used
   assign bus_req_wdata = first_issue ? dmem_wdata_delayed : wdata_q;

   // Byte enables and alignment check for the access presented in this cycle
   always_comb begin
      strb_new = '1;
      misal    = 1'b0;
      case (dmem_size)
         3'd0: begin
            strb_new = STRB_W'(4'b0001 << dmem_addr[1:0]);
         end
         3'd1: begin
            strb_new = STRB_W'(4'b0011 << {dmem_addr[1], 1'b0});
            misal    = dmem_addr[0];
         end
         default: begin
            strb_new = '1;
            misal    = (dmem_addr[1:0] != 2'b00);
         end
      endcase
   end

   // Main FSM: accept, issue, wait for response, present result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         count         <= 8'd0;
         wait_q        <= 1'b0;
         badmem_q      <= 1'b0;
         rdata_q       <= '0;
         wdata_q       <= '0;
         first_issue   <= 1'b0;
         bus_req_valid <= 1'b0;
         bus_req_wen   <= 1'b0;
         bus_req_addr  <= '0;
         bus_req_strb  <= '0;
      end else begin
         first_issue <= 1'b0;
         badmem_q    <= 1'b0;
         if (first_issue) begin
            wdata_q <= dmem_wdata_delayed;
         end
         if (fast_hit) begin
            rdata_q <= bus_resp_rdata;
         end
         if (accept) begin
            bus_req_addr <= {dmem_addr[ADDR_W-1:2], 2'b00};
            bus_req_wen  <= dmem_wen;
            bus_req_strb <= strb_new;
            if (misal) begin
               // Never reaches the bus; report the error in the following cycle
               state    <= DONE;
               badmem_q <= 1'b1;
               wait_q   <= 1'b0;
            end else begin
               state         <= ISSUE;
               bus_req_valid <= 1'b1;
               wait_q        <= 1'b1;
               first_issue   <= 1'b1;
            end
         end else begin
            case (state)
               IDLE, DONE: begin
                  state  <= IDLE;
                  wait_q <= 1'b0;
               end
               ISSUE: begin
                  if (bus_req_ready) begin
                     bus_req_valid <= 1'b0;
                     state         <= RESP;
                     count         <= 8'd0;
                  end
               end
               RESP: begin
                  if (bus_resp_valid) begin
                     wait_q <= 1'b0;
`ifdef VSCALE_DMEM_BRIDGE_FASTRESP_EN
                     state  <= IDLE;
`else
                     state    <= DONE;
                     rdata_q  <= bus_resp_rdata;
                     badmem_q <= bus_resp_err;
`endif
                  end else if ((TIMEOUT_CNT != 8'd0) && (count_nxt == TIMEOUT_CNT)) begin
                     state    <= DONE;
                     wait_q   <= 1'b0;
                     badmem_q <= 1'b1;
                     rdata_q  <= '0;
                  end else begin
                     count <= count_nxt;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Bench for vscale_dmem_bridge: directed vector table plus hand-written multi-cycle sequences.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Build with VSCALE_DMEM_BRIDGE_FASTRESP_EN defined to exercise the fast-response variant.
module tb_vscale_dmem_bridge;

   logic        clk;
   logic        reset_n;
   logic        dmem_en;
   logic        dmem_wen;
   logic [2:0]  dmem_size;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata_delayed;
   logic        dmem_wait;
   logic [31:0] dmem_rdata;
   logic        dmem_badmem_e;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_wen;
   logic [31:0] bus_req_addr;
   logic [31:0] bus_req_wdata;
   logic [3:0]  bus_req_strb;
   logic        bus_resp_valid;
   logic [31:0] bus_resp_rdata;
   logic        bus_resp_err;

   int total = 0;
   int bad   = 0;

   vscale_dmem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
      .dmem_wdata_delayed(dmem_wdata_delayed), .dmem_wait(dmem_wait), .dmem_rdata(dmem_rdata),
      .dmem_badmem_e(dmem_badmem_e), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_req_wen(bus_req_wen), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
      .bus_req_strb(bus_req_strb), .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
      .bus_resp_err(bus_resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          rdy_dly;
      int          rsp_dly;
      logic        early;
      logic [31:0] rsp_data;
      logic        rsp_err;
      logic        misal;
      logic [31:0] exp_addr;
      logic [3:0]  exp_strb;
   } vec_t;

   vec_t tbl[10];

   function automatic vec_t mk(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                               input logic early, input logic [31:0] rsp_data, input logic rsp_err,
                               input logic misal, input logic [31:0] exp_addr, input logic [3:0] exp_strb);
      vec_t v;
      v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata;
      v.rdy_dly = rdy_dly; v.rsp_dly = rsp_dly; v.early = early;
      v.rsp_data = rsp_data; v.rsp_err = rsp_err; v.misal = misal;
      v.exp_addr = exp_addr; v.exp_strb = exp_strb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc_start();
      @(posedge clk);
      #1;
   endtask

   // One full pipeline access driven from IDLE and checked cycle by cycle
   task automatic do_vec(input int k, input vec_t v);
      int nwait;
      int exp_stall;
      nwait = 0;
      cyc_start();
      dmem_en = 1'b1; dmem_wen = v.wen; dmem_size = v.size; dmem_addr = v.addr;
      dmem_wdata_delayed = 32'h0;
      @(negedge clk);
      chk($sformatf("v%0d acc_wait", k), 32'(dmem_wait), 32'd0);
      chk($sformatf("v%0d acc_valid", k), 32'(bus_req_valid), 32'd0);
      chk($sformatf("v%0d acc_bad", k), 32'(dmem_badmem_e), 32'd0);
      cyc_start();
      dmem_en = 1'b0; dmem_addr = 32'hFFFF_FFFF; dmem_wdata_delayed = v.wdata;
      if (v.misal) begin
         @(negedge clk);
         chk($sformatf("v%0d mis_valid", k), 32'(bus_req_valid), 32'd0);
         chk($sformatf("v%0d mis_wait", k), 32'(dmem_wait), 32'd0);
         chk($sformatf("v%0d mis_bad", k), 32'(dmem_badmem_e), 32'd1);
      end else begin
         for (int i = 0; i <= v.rdy_dly; i++) begin
            if (i > 0) begin
               cyc_start();
               dmem_wdata_delayed = ~v.wdata;
            end
            bus_req_ready  = (i == v.rdy_dly);
            bus_resp_valid = (i == v.rdy_dly) && v.early;
            bus_resp_rdata = 32'hBAD0_BAD0;
            bus_resp_err   = bus_resp_valid;
            @(negedge clk);
            if (dmem_wait) nwait++;
            chk($sformatf("v%0d iss_valid", k), 32'(bus_req_valid), 32'd1);
            chk($sformatf("v%0d iss_addr", k), bus_req_addr, v.exp_addr);
            chk($sformatf("v%0d iss_strb", k), 32'(bus_req_strb), 32'(v.exp_strb));
            chk($sformatf("v%0d iss_wen", k), 32'(bus_req_wen), 32'(v.wen));
            if (v.wen) chk($sformatf("v%0d iss_wdata", k), bus_req_wdata, v.wdata);
         end
         for (int j = 0; j <= v.rsp_dly; j++) begin
            cyc_start();
            bus_req_ready  = 1'b0;
            bus_resp_valid = (j == v.rsp_dly);
            bus_resp_rdata = bus_resp_valid ? v.rsp_data : 32'h5555_AAAA;
            bus_resp_err   = bus_resp_valid ? v.rsp_err : 1'b0;
            @(negedge clk);
            if (dmem_wait) nwait++;
            chk($sformatf("v%0d resp_valid", k), 32'(bus_req_valid), 32'd0);
`ifdef VSCALE_DMEM_BRIDGE_FASTRESP_EN
            if (j == v.rsp_dly) begin
               chk($sformatf("v%0d fast_rdata", k), dmem_rdata, v.rsp_data);
               chk($sformatf("v%0d fast_bad", k), 32'(dmem_badmem_e), 32'(v.rsp_err));
            end
`endif
         end
         cyc_start();
         bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
`ifndef VSCALE_DMEM_BRIDGE_FASTRESP_EN
         @(negedge clk);
         chk($sformatf("v%0d done_wait", k), 32'(dmem_wait), 32'd0);
         chk($sformatf("v%0d done_rdata", k), dmem_rdata, v.rsp_data);
         chk($sformatf("v%0d done_bad", k), 32'(dmem_badmem_e), 32'(v.rsp_err));
         cyc_start();
`endif
         @(negedge clk);
         chk($sformatf("v%0d idle_wait", k), 32'(dmem_wait), 32'd0);
         chk($sformatf("v%0d idle_bad", k), 32'(dmem_badmem_e), 32'd0);
         chk($sformatf("v%0d idle_rdata", k), dmem_rdata, v.rsp_data);
         exp_stall = v.rdy_dly + v.rsp_dly + 2;
`ifdef VSCALE_DMEM_BRIDGE_FASTRESP_EN
         exp_stall = exp_stall - 1;
`endif
         chk($sformatf("v%0d stall", k), 32'(nwait), 32'(exp_stall));
      end
   endtask

   // Checks that every DUT output is zero right now
   task automatic chk_zero(input string tag);
      chk({tag, " wait"}, 32'(dmem_wait), 32'd0);
      chk({tag, " rdata"}, dmem_rdata, 32'd0);
      chk({tag, " bad"}, 32'(dmem_badmem_e), 32'd0);
      chk({tag, " valid"}, 32'(bus_req_valid), 32'd0);
      chk({tag, " wen"}, 32'(bus_req_wen), 32'd0);
      chk({tag, " addr"}, bus_req_addr, 32'd0);
      chk({tag, " wdata"}, bus_req_wdata, 32'd0);
      chk({tag, " strb"}, 32'(bus_req_strb), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            wen size addr          wdata         rdy rsp early rsp_data      err mis exp_addr      strb
      tbl[0] = mk(1'b0, 3'd2, 32'h0000_0100, 32'h0,        0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0100, 4'hF);
      tbl[1] = mk(1'b1, 3'd0, 32'h0000_0103, 32'h5A5A_5A5A, 3, 0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0100, 4'b1000);
      tbl[2] = mk(1'b0, 3'd1, 32'h0000_0201, 32'h0,        0, 0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         4'h0);
      tbl[3] = mk(1'b0, 3'd1, 32'h0000_0042, 32'h0,        0, 1, 1'b0, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_0040, 4'b1100);
      tbl[4] = mk(1'b0, 3'd0, 32'h0000_0000, 32'h0,        1, 2, 1'b1, 32'h0000_00AA, 1'b0, 1'b0, 32'h0000_0000, 4'b0001);
      tbl[5] = mk(1'b0, 3'd3, 32'h0000_01FC, 32'h0,        0, 0, 1'b0, 32'h7654_3210, 1'b0, 1'b0, 32'h0000_01FC, 4'hF);
      tbl[6] = mk(1'b1, 3'd1, 32'h0000_3002, 32'hBEEF_BEEF, 1, 1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3000, 4'b1100);
      tbl[7] = mk(1'b0, 3'd0, 32'h0000_0005, 32'h0,        0, 0, 1'b0, 32'h0000_BB00, 1'b0, 1'b0, 32'h0000_0004, 4'b0010);
      tbl[8] = mk(1'b0, 3'd7, 32'h0000_0001, 32'h0,        0, 0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         4'h0);
      tbl[9] = mk(1'b0, 3'd2, 32'h0000_0102, 32'h0,        0, 0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         4'h0);

      reset_n = 1'b0; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = 32'h0;
      dmem_wdata_delayed = 32'h0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
      bus_resp_rdata = 32'h0; bus_resp_err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      cyc_start();
      reset_n = 1'b1;

      for (int k = 0; k < 10; k++) do_vec(k, tbl[k]);

      // Timeout: no response for 4 RESP cycles forces an error with zero data
      cyc_start();
      dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h0000_0500;
      cyc_start();
      dmem_en = 1'b0; bus_req_ready = 1'b1;
      @(negedge clk);
      chk("to issue_valid", 32'(bus_req_valid), 32'd1);
      for (int j = 0; j < 4; j++) begin
         cyc_start();
         bus_req_ready = 1'b0;
         @(negedge clk);
         chk($sformatf("to resp%0d_wait", j), 32'(dmem_wait), 32'd1);
      end
      cyc_start();
      @(negedge clk);
      chk("to done_wait", 32'(dmem_wait), 32'd0);
      chk("to done_bad", 32'(dmem_badmem_e), 32'd1);
      chk("to done_rdata", dmem_rdata, 32'd0);
      cyc_start();
      @(negedge clk);
      chk("to idle_bad", 32'(dmem_badmem_e), 32'd0);

      // Back-to-back loads: second access accepted in the result cycle of the first
      cyc_start();
      dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h0000_0010;
      cyc_start();
      dmem_en = 1'b0; bus_req_ready = 1'b1;
      @(negedge clk);
      chk("b2b a_valid", 32'(bus_req_valid), 32'd1);
      cyc_start();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h1111_1111; bus_resp_err = 1'b0;
`ifdef VSCALE_DMEM_BRIDGE_FASTRESP_EN
      dmem_en = 1'b1; dmem_addr = 32'h0000_0014;
      @(negedge clk);
`else
      @(negedge clk);
      chk("b2b a_resp_wait", 32'(dmem_wait), 32'd1);
      cyc_start();
      bus_resp_valid = 1'b0; dmem_en = 1'b1; dmem_addr = 32'h0000_0014;
      @(negedge clk);
`endif
      chk("b2b a_wait", 32'(dmem_wait), 32'd0);
      chk("b2b a_rdata", dmem_rdata, 32'h1111_1111);
      cyc_start();
      dmem_en = 1'b0; bus_resp_valid = 1'b0; bus_req_ready = 1'b1;
      @(negedge clk);
      chk("b2b b_valid", 32'(bus_req_valid), 32'd1);
      chk("b2b b_addr", bus_req_addr, 32'h0000_0014);
      chk("b2b b_wait", 32'(dmem_wait), 32'd1);
      cyc_start();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h2222_2222;
`ifndef VSCALE_DMEM_BRIDGE_FASTRESP_EN
      @(negedge clk);
      cyc_start();
      bus_resp_valid = 1'b0;
`endif
      @(negedge clk);
      chk("b2b b_rdata", dmem_rdata, 32'h2222_2222);
      chk("b2b b_done_wait", 32'(dmem_wait), 32'd0);
      cyc_start();
      bus_resp_valid = 1'b0;

      // Reset asserted while waiting for a response
      cyc_start();
      dmem_en = 1'b1; dmem_size = 3'd2; dmem_addr = 32'h0000_0600;
      cyc_start();
      dmem_en = 1'b0; bus_req_ready = 1'b1;
      cyc_start();
      bus_req_ready = 1'b0;
      @(negedge clk);
      chk("rst resp_wait", 32'(dmem_wait), 32'd1);
      #2 reset_n = 1'b0;
      #1 chk_zero("rst async");
      cyc_start();
      reset_n = 1'b1;
      cyc_start();
      bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFE_F00D; bus_resp_err = 1'b1;
      @(negedge clk);
      chk("rst late_wait", 32'(dmem_wait), 32'd0);
      chk("rst late_rdata", dmem_rdata, 32'd0);
      chk("rst late_bad", 32'(dmem_badmem_e), 32'd0);
      cyc_start();
      bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
      @(negedge clk);
      chk("rst after_rdata", dmem_rdata, 32'd0);
      chk("rst after_bad", 32'(dmem_badmem_e), 32'd0);
      do_vec(10, tbl[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
